mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM pipeline stage between the EX/MEM register and the write-back MemtoReg mux. It performs loads and stores over a req/ack data-memory port with byte, halfword and word sizes. It extracts and sign- or zero-extends load data and produces the registered WB-side signals: `ALU_Result_WB`, `Read_Data_WB`, `MemtoReg_WB` and the register-write controls. It stalls upstream while a memory access is outstanding.

## Interface
Parameters: none.

Ports (all widths in bits):
- `Clk` — in, 1. Single clock; all state on its rising edge.
- `Reset_n` — in, 1. Asynchronous, active-low reset.
- `Valid_MEM` — in, 1. Instruction present in MEM.
- `ALU_Result_MEM` — in, 32. Effective address, or the result for non-memory ops.
- `Store_Data_MEM` — in, 32. Store source register value.
- `MemRead_MEM`, `MemWrite_MEM` — in, 1 each. Load or store; never both set.
- `Size_MEM` — in, 2. 00 byte, 01 half, 10 word; 11 is treated as word.
- `Unsigned_MEM` — in, 1. Zero-extend loads when 1.
- `MemtoReg_MEM`, `RegWrite_MEM` — in, 1 each. Forwarded controls.
- `Write_Reg_MEM` — in, 5. Destination register.
- `Mem_Req` — out, 1. Memory request.
- `Mem_We` — out, 1. Write request.
- `Mem_Addr` — out, 32. Word address, bits [1:0] = 00.
- `Mem_Be` — out, 4. Byte enables, little-endian.
- `Mem_Wdata` — out, 32. Lane-replicated store data.
- `Mem_Ack` — in, 1. Access complete; read data valid.
- `Mem_Rdata` — in, 32. Read word.
- `Stall_MEM` — out, 1. Upstream must hold its MEM-stage inputs.
- `Misaligned_Exc` — out, 1. One-cycle pulse on an alignment fault.
- `ALU_Result_WB` — out, 32. Registered WB-side output.
- `Read_Data_WB` — out, 32. Registered WB-side output.
- `Write_Reg_WB` — out, 5. Registered WB-side output.
- `MemtoReg_WB`, `RegWrite_WB`, `Valid_WB` — out, 1 each. Registered WB-side outputs.

## Operation
- FSM has two states, IDLE and ACCESS. Reset enters IDLE.
- **Memory op definition:** `Valid_MEM & (MemRead_MEM | MemWrite_MEM)`.
- **Aligned:** byte always; half requires addr[0]=0; word requires addr[1:0]=00.
- **IDLE, non-memory op or Valid_MEM=0:**
  - WB registers load the MEM inputs; `Valid_WB <= Valid_MEM`.
  - `RegWrite_WB <= RegWrite_MEM & Valid_MEM`.
  - No stall.
- **IDLE, aligned memory op:**
  - Latch address, size, unsigned flag, write flag, Be and Wdata; go to ACCESS.
  - `Stall_MEM=1` combinationally.
  - WB registers get a bubble: `Valid_WB=0`, `RegWrite_WB=0`.
- **IDLE, misaligned memory op:**
  - No request is issued.
  - `Misaligned_Exc=1` for that cycle (registered pulse next edge).
  - WB registers get a bubble; stay in IDLE; no stall.
- **ACCESS:**
  - `Mem_Req=1` with the latched `Mem_We`, `Mem_Addr`, `Mem_Be`, `Mem_Wdata`, all held stable until ack.
  - `Stall_MEM = ~Mem_Ack`.
  - On `Mem_Ack`: WB registers load, `Valid_WB=1`, and the FSM returns to IDLE.
  - `Read_Data_WB` gets the extracted load data; for stores it gets 0.
- **Byte enables:**
  - Byte: 0001 shifted left by addr[1:0].
  - Half: 0011 if addr[1]=0, else 1100.
  - Word: 1111.
- **Wdata:** byte replicated ×4; half replicated ×2; word as-is.
- **Load extraction:**
  - Byte lane = `Mem_Rdata >> 8*addr[1:0]`, bits [7:0].
  - Half lane = `Mem_Rdata >> 16*addr[1]`, bits [15:0].
  - Extension: sign-extend unless `Unsigned_MEM`.
- `Mem_Ack` outside ACCESS is ignored.

## Timing
- **Reset values:** all outputs 0 (`Mem_Req`, `Mem_We`, `Mem_Addr`, `Mem_Be`, `Mem_Wdata`, `Stall_MEM`, `Misaligned_Exc`, all `*_WB`).
- **Reset mid-access:** `Mem_Req` drops immediately (asynchronous); the FSM returns to IDLE and the access is abandoned.
- **Non-memory op latency:** 1 cycle, MEM inputs to WB registers.
- **Memory op latency:** accepted at edge N; `Mem_Req` is high from cycle N+1.
  - Ack in the first ACCESS cycle → WB valid after edge N+2, so 2 cycles minimum.
  - Each extra wait cycle adds 1.
- **Upstream handshake:** `Stall_MEM` is high from the accept cycle through the cycle before ack, and low in the ack cycle. The next instruction is therefore consumed at the ack edge, and back-to-back memory ops re-enter ACCESS immediately.
- **Memory port:** one outstanding request; request fields never change while `Mem_Req=1`.

## Test plan
- **ALU op:** `ALU_Result_MEM=0x1234`, `RegWrite_MEM=1`, no memory op → next cycle `ALU_Result_WB=0x1234`, `Valid_WB=1`, `RegWrite_WB=1`, no `Mem_Req`.
- **Signed byte load with wait:** lb at addr 0x103, ack after 3 wait cycles, `Rdata=0x80FF7F01` → `Mem_Addr=0x100`, `Mem_Be=1000`, `Stall_MEM` high for 4 cycles, `Read_Data_WB=0xFFFFFF80`. Repeat with `Unsigned_MEM=1` → `0x00000080`.
- **Halfword store:** sh at 0x202 with data 0xABCD1234 → `Mem_We=1`, `Mem_Be=1100`, `Mem_Wdata=0x12341234`, `Mem_Addr=0x200`, `Read_Data_WB=0`.
- **Misaligned word load:** lw at 0x301 → no `Mem_Req`, `Misaligned_Exc` pulses 1 cycle, `Valid_WB=0`, `RegWrite_WB=0`.
- **Back-to-back with stray ack:** lw 0x400 then sw 0x404, both acked in their first ACCESS cycle → each completes in 2 cycles. A stray `Mem_Ack` in IDLE is ignored.
- **Reset mid-access:** deassert `Reset_n` in ACCESS → `Mem_Req` and all outputs 0 immediately; after release, FSM in IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: req/ack data-memory access, load extraction, WB registers
module mem_access_stage (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Valid_MEM,
   input  logic [31:0] ALU_Result_MEM,
   input  logic [31:0] Store_Data_MEM,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic [1:0]  Size_MEM,
   input  logic        Unsigned_MEM,
   input  logic        MemtoReg_MEM,
   input  logic        RegWrite_MEM,
   input  logic [4:0]  Write_Reg_MEM,
   output logic        Mem_Req,
   output logic        Mem_We,
   output logic [31:0] Mem_Addr,
   output logic [3:0]  Mem_Be,
   output logic [31:0] Mem_Wdata,
   input  logic        Mem_Ack,
   input  logic [31:0] Mem_Rdata,
   output logic        Stall_MEM,
   output logic        Misaligned_Exc,
   output logic [31:0] ALU_Result_WB,
   output logic [31:0] Read_Data_WB,
   output logic [4:0]  Write_Reg_WB,
   output logic        MemtoReg_WB,
   output logic        RegWrite_WB,
   output logic        Valid_WB
);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t      r_state, w_next;
   logic [31:0] r_addr, r_wdata;
   logic [1:0]  r_size;
   logic        r_unsigned, r_we, r_memtoreg, r_regwrite, r_misaligned;
   logic [3:0]  r_be;
   logic [4:0]  r_wreg;
   logic [31:0] r_alu_wb, r_rdata_wb;
   logic [4:0]  r_wreg_wb;
   logic        r_memtoreg_wb, r_regwrite_wb, r_valid_wb;

   logic        w_mem_op, w_aligned, w_stall;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_load;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_mem_op = Valid_MEM & (MemRead_MEM | MemWrite_MEM);

   always_comb begin
      w_aligned = 1'b1;
      w_be      = 4'b1111;
      w_wdata   = Store_Data_MEM;
      case (Size_MEM)
         2'b00: begin
            w_be    = 4'b0001 << ALU_Result_MEM[1:0];
            w_wdata = {4{Store_Data_MEM[7:0]}};
         end
         2'b01: begin
            w_aligned = ~ALU_Result_MEM[0];
            w_be      = ALU_Result_MEM[1] ? 4'b1100 : 4'b0011;
            w_wdata   = {2{Store_Data_MEM[15:0]}};
         end
         default: w_aligned = (ALU_Result_MEM[1:0] == 2'b00);
      endcase
   end

   // Extraction uses the latched address/size, since upstream may change at the ack edge.
   always_comb begin
      case (r_addr[1:0])
         2'd0:    w_byte = Mem_Rdata[7:0];
         2'd1:    w_byte = Mem_Rdata[15:8];
         2'd2:    w_byte = Mem_Rdata[23:16];
         default: w_byte = Mem_Rdata[31:24];
      endcase
      w_half = r_addr[1] ? Mem_Rdata[31:16] : Mem_Rdata[15:0];
      case (r_size)
         2'b00:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = Mem_Rdata;
      endcase
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op && w_aligned) begin
               w_next  = S_ACCESS;
               w_stall = 1'b1;
            end
         end
         default: begin
            w_stall = ~Mem_Ack;
            if (Mem_Ack) w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_addr        <= '0;
         r_wdata       <= '0;
         r_size        <= '0;
         r_unsigned    <= 1'b0;
         r_we          <= 1'b0;
         r_be          <= '0;
         r_wreg        <= '0;
         r_memtoreg    <= 1'b0;
         r_regwrite    <= 1'b0;
         r_misaligned  <= 1'b0;
         r_alu_wb      <= '0;
         r_rdata_wb    <= '0;
         r_wreg_wb     <= '0;
         r_memtoreg_wb <= 1'b0;
         r_regwrite_wb <= 1'b0;
         r_valid_wb    <= 1'b0;
      end else begin
         r_misaligned <= (r_state == S_IDLE) & w_mem_op & ~w_aligned;
         if (r_state == S_IDLE) begin
            if (w_mem_op && w_aligned) begin
               r_addr     <= ALU_Result_MEM;
               r_wdata    <= w_wdata;
               r_size     <= Size_MEM;
               r_unsigned <= Unsigned_MEM;
               r_we       <= MemWrite_MEM;
               r_be       <= w_be;
               r_wreg     <= Write_Reg_MEM;
               r_memtoreg <= MemtoReg_MEM;
               r_regwrite <= RegWrite_MEM;
            end
            r_alu_wb      <= ALU_Result_MEM;
            r_rdata_wb    <= '0;
            r_wreg_wb     <= Write_Reg_MEM;
            r_memtoreg_wb <= MemtoReg_MEM;
            // Any memory op leaves a bubble here; the real result appears on ack.
            r_valid_wb    <= Valid_MEM & ~w_mem_op;
            r_regwrite_wb <= RegWrite_MEM & Valid_MEM & ~w_mem_op;
         end else if (Mem_Ack) begin
            r_alu_wb      <= r_addr;
            r_rdata_wb    <= r_we ? 32'h0 : w_load;
            r_wreg_wb     <= r_wreg;
            r_memtoreg_wb <= r_memtoreg;
            r_regwrite_wb <= r_regwrite;
            r_valid_wb    <= 1'b1;
         end
      end
   end

   assign Mem_Req        = (r_state == S_ACCESS);
   assign Mem_We         = r_we;
   assign Mem_Addr       = {r_addr[31:2], 2'b00};
   assign Mem_Be         = r_be;
   assign Mem_Wdata      = r_wdata;
   assign Stall_MEM      = w_stall & Reset_n;
   assign Misaligned_Exc = r_misaligned;
   assign ALU_Result_WB  = r_alu_wb;
   assign Read_Data_WB   = r_rdata_wb;
   assign Write_Reg_WB   = r_wreg_wb;
   assign MemtoReg_WB    = r_memtoreg_wb;
   assign RegWrite_WB    = r_regwrite_wb;
   assign Valid_WB       = r_valid_wb;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard testbench for mem_access_stage
module tb_mem_access_stage;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Valid_MEM, MemRead_MEM, MemWrite_MEM, Unsigned_MEM, MemtoReg_MEM, RegWrite_MEM;
   logic [31:0] ALU_Result_MEM, Store_Data_MEM;
   logic [1:0]  Size_MEM;
   logic [4:0]  Write_Reg_MEM;
   logic        Mem_Req, Mem_We, Mem_Ack, Stall_MEM, Misaligned_Exc;
   logic [31:0] Mem_Addr, Mem_Wdata, Mem_Rdata;
   logic [3:0]  Mem_Be;
   logic [31:0] ALU_Result_WB, Read_Data_WB;
   logic [4:0]  Write_Reg_WB;
   logic        MemtoReg_WB, RegWrite_WB, Valid_WB;

   always #5 Clk = ~Clk;

   mem_access_stage dut (
      .Clk(Clk), .Reset_n(Reset_n), .Valid_MEM(Valid_MEM),
      .ALU_Result_MEM(ALU_Result_MEM), .Store_Data_MEM(Store_Data_MEM),
      .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Size_MEM(Size_MEM),
      .Unsigned_MEM(Unsigned_MEM), .MemtoReg_MEM(MemtoReg_MEM), .RegWrite_MEM(RegWrite_MEM),
      .Write_Reg_MEM(Write_Reg_MEM), .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
      .Mem_Be(Mem_Be), .Mem_Wdata(Mem_Wdata), .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata),
      .Stall_MEM(Stall_MEM), .Misaligned_Exc(Misaligned_Exc), .ALU_Result_WB(ALU_Result_WB),
      .Read_Data_WB(Read_Data_WB), .Write_Reg_WB(Write_Reg_WB), .MemtoReg_WB(MemtoReg_WB),
      .RegWrite_WB(RegWrite_WB), .Valid_WB(Valid_WB)
   );

   typedef struct {
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [4:0]  wreg;
      logic        m2r;
      logic        rw;
   } wb_t;

   wb_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin : monitor
      wb_t e;
      if (Reset_n === 1'b1 && Valid_WB === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_unexpected: got Valid_WB=1 alu=0x%08h expected no result", ALU_Result_WB);
         end else begin
            e = exp_q.pop_front();
            chk("wb_alu",      ALU_Result_WB, e.alu);
            chk("wb_rdata",    Read_Data_WB,  e.rdata);
            chk("wb_wreg",     32'(Write_Reg_WB), 32'(e.wreg));
            chk("wb_memtoreg", 32'(MemtoReg_WB),  32'(e.m2r));
            chk("wb_regwrite", 32'(RegWrite_WB),  32'(e.rw));
         end
      end
   end

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic m2r, input logic rw, input logic [4:0] wreg);
      Valid_MEM = v; MemRead_MEM = rd; MemWrite_MEM = wr; Size_MEM = sz;
      Unsigned_MEM = uns; ALU_Result_MEM = addr; Store_Data_MEM = sdata;
      MemtoReg_MEM = m2r; RegWrite_MEM = rw; Write_Reg_MEM = wreg;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
   endtask

   // Called with the op already on the MEM inputs; returns #1 after the ack edge.
   task automatic do_mem(input int waits, input logic [31:0] rdata,
                         output int stalls, output int reqs, output logic stable,
                         output logic [31:0] addr, output logic [31:0] wdata,
                         output logic [3:0] be, output logic we);
      stalls = 0; reqs = 0; stable = 1'b1;
      addr = '0; wdata = '0; be = '0; we = 1'b0;
      @(negedge Clk);
      stalls = stalls + int'(Stall_MEM);
      @(posedge Clk); #1;
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            Mem_Ack = 1'b1;
            Mem_Rdata = rdata;
         end
         @(negedge Clk);
         stalls = stalls + int'(Stall_MEM);
         reqs   = reqs + int'(Mem_Req);
         if (i == 0) begin
            addr = Mem_Addr; wdata = Mem_Wdata; be = Mem_Be; we = Mem_We;
         end else if ({Mem_Addr, Mem_Wdata, Mem_Be, Mem_We} !== {addr, wdata, be, we}) begin
            stable = 1'b0;
         end
         @(posedge Clk); #1;
         Mem_Ack = 1'b0;
         Mem_Rdata = 32'h0;
      end
   endtask

   int          st, rq;
   logic        stb, we;
   logic [31:0] a, wd;
   logic [3:0]  be;

   initial begin
      Reset_n = 1'b0;
      Mem_Ack = 1'b0;
      Mem_Rdata = 32'h0;
      idle();
      repeat (2) @(negedge Clk);
      chk("rst_addr",    Mem_Addr, 32'h0);
      chk("rst_wdata",   Mem_Wdata, 32'h0);
      chk("rst_ctrl",    32'({Mem_Req, Mem_We, Mem_Be, Stall_MEM, Misaligned_Exc}), 32'h0);
      chk("rst_wb_alu",  ALU_Result_WB, 32'h0);
      chk("rst_wb_rd",   Read_Data_WB, 32'h0);
      chk("rst_wb_ctrl", 32'({Write_Reg_WB, MemtoReg_WB, RegWrite_WB, Valid_WB}), 32'h0);
      Reset_n = 1'b1;
      @(posedge Clk); #1;

      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5);
      exp_q.push_back('{32'h1234, 32'h0, 5'd5, 1'b0, 1'b1});
      @(negedge Clk);
      chk("alu_req",   32'(Mem_Req), 32'h0);
      chk("alu_stall", 32'(Stall_MEM), 32'h0);
      @(posedge Clk); #1;
      idle();
      @(negedge Clk);
      chk("alu_valid", 32'(Valid_WB), 32'h1);
      @(posedge Clk); #1;

      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, 1'b1, 5'd7);
      exp_q.push_back('{32'h103, 32'hFFFFFF80, 5'd7, 1'b1, 1'b1});
      do_mem(3, 32'h80FF7F01, st, rq, stb, a, wd, be, we);
      idle();
      chk("lb_stall",  32'(st), 32'd4);
      chk("lb_req",    32'(rq), 32'd4);
      chk("lb_addr",   a, 32'h100);
      chk("lb_be",     32'(be), 32'h8);
      chk("lb_we",     32'(we), 32'h0);
      chk("lb_stable", 32'(stb), 32'h1);

      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, 1'b1, 5'd8);
      exp_q.push_back('{32'h103, 32'h00000080, 5'd8, 1'b1, 1'b1});
      do_mem(3, 32'h80FF7F01, st, rq, stb, a, wd, be, we);
      idle();
      chk("lbu_stall", 32'(st), 32'd4);

      drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'hABCD1234, 1'b0, 1'b0, 5'd0);
      exp_q.push_back('{32'h202, 32'h0, 5'd0, 1'b0, 1'b0});
      do_mem(1, 32'hFFFFFFFF, st, rq, stb, a, wd, be, we);
      idle();
      chk("sh_we",     32'(we), 32'h1);
      chk("sh_be",     32'(be), 32'hC);
      chk("sh_wdata",  wd, 32'h12341234);
      chk("sh_addr",   a, 32'h200);
      chk("sh_stall",  32'(st), 32'd2);
      chk("sh_stable", 32'(stb), 32'h1);

      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 1'b1, 1'b1, 5'd9);
      @(negedge Clk);
      chk("mis_req0",   32'(Mem_Req), 32'h0);
      chk("mis_stall",  32'(Stall_MEM), 32'h0);
      chk("mis_exc0",   32'(Misaligned_Exc), 32'h0);
      @(posedge Clk); #1;
      idle();
      @(negedge Clk);
      chk("mis_exc",    32'(Misaligned_Exc), 32'h1);
      chk("mis_valid",  32'(Valid_WB), 32'h0);
      chk("mis_rw",     32'(RegWrite_WB), 32'h0);
      chk("mis_req1",   32'(Mem_Req), 32'h0);
      @(negedge Clk);
      chk("mis_pulse",  32'(Misaligned_Exc), 32'h0);
      @(posedge Clk); #1;

      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 5'd10);
      exp_q.push_back('{32'h400, 32'hDEADBEEF, 5'd10, 1'b1, 1'b1});
      do_mem(0, 32'hDEADBEEF, st, rq, stb, a, wd, be, we);
      chk("b2b_lw_stall", 32'(st), 32'd1);
      chk("b2b_lw_addr",  a, 32'h400);
      chk("b2b_lw_be",    32'(be), 32'hF);
      drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h404, 32'h55AA0011, 1'b0, 1'b0, 5'd0);
      exp_q.push_back('{32'h404, 32'h0, 5'd0, 1'b0, 1'b0});
      do_mem(0, 32'h12345678, st, rq, stb, a, wd, be, we);
      idle();
      chk("b2b_sw_stall", 32'(st), 32'd1);
      chk("b2b_sw_req",   32'(rq), 32'd1);
      chk("b2b_sw_we",    32'(we), 32'h1);
      chk("b2b_sw_wdata", wd, 32'h55AA0011);
      chk("b2b_sw_addr",  a, 32'h404);
      @(negedge Clk);
      chk("b2b_sw_valid", 32'(Valid_WB), 32'h1);

      @(posedge Clk); #1;
      Mem_Ack = 1'b1;
      Mem_Rdata = 32'hFFFFFFFF;
      @(negedge Clk);
      chk("stray_stall", 32'(Stall_MEM), 32'h0);
      @(posedge Clk); #1;
      Mem_Ack = 1'b0;
      Mem_Rdata = 32'h0;
      @(negedge Clk);
      chk("stray_req",   32'(Mem_Req), 32'h0);
      chk("stray_valid", 32'(Valid_WB), 32'h0);

      @(posedge Clk); #1;
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 1'b1, 1'b1, 5'd11);
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("rma_req_on", 32'(Mem_Req), 32'h1);
      #1 Reset_n = 1'b0;
      #1;
      chk("rma_req",   32'(Mem_Req), 32'h0);
      chk("rma_stall", 32'(Stall_MEM), 32'h0);
      chk("rma_addr",  Mem_Addr, 32'h0);
      chk("rma_ctrl",  32'({Mem_We, Mem_Be, Valid_WB, RegWrite_WB}), 32'h0);
      @(posedge Clk); #1;
      idle();
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("rma_idle_req",   32'(Mem_Req), 32'h0);
      chk("rma_idle_stall", 32'(Stall_MEM), 32'h0);
      @(posedge Clk); #1;
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'hCAFE, 32'h0, 1'b0, 1'b1, 5'd3);
      exp_q.push_back('{32'hCAFE, 32'h0, 5'd3, 1'b0, 1'b1});
      @(posedge Clk); #1;
      idle();
      @(negedge Clk);
      chk("post_rst_valid", 32'(Valid_WB), 32'h1);

      repeat (3) @(negedge Clk);
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
